// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the sysid boot checker: FSM states, slave word addresses, widths.
package sysid_check_pkg;

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CMP, DONE} state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   DATA_W        = 32;
  localparam int   LAT_W         = 3;

  function automatic logic is_active(input state_t s);
    return (s == RD_ID) || (s == RD_TS) || (s == CMP);
  endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link to the Qsys sysid slave; no waitrequest, fixed read latency.
interface sysid_boot_checker_if;
  import sysid_check_pkg::*;

  logic              sysid_address;
  logic              sysid_read;
  logic [DATA_W-1:0] sysid_readdata;

  modport master (output sysid_address, output sysid_read, input sysid_readdata);
  modport slave  (input sysid_address, input sysid_read, output sysid_readdata);

endinterface

// File: rtl/sysid_boot_checker_read_timer.sv
// Load/count-down timer: sample is high on terminal count (0); reloads whenever load is high.
module sysid_read_timer
  import sysid_check_pkg::*;
#(
  parameter int LOAD_VAL = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  output logic o_sample
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LAT_W'(LOAD_VAL);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_sample = (r_cnt == '0);

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads sysid ID/timestamp words, compares to build-time values, retries, gates boot via pass; all outputs registered.
// Optional SYSID_PERIODIC_RECHECK_EN re-runs the check every RECHECK_PERIOD cycles while in DONE, keeping pass.
module sysid_boot_checker
  import sysid_check_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID  = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TS  = 32'd1671663468,
  parameter int                READ_LATENCY = 1,
  parameter int                MAX_RETRIES  = 3,
  parameter bit                AUTO_START   = 1'b1
`ifdef SYSID_PERIODIC_RECHECK_EN
  ,parameter int unsigned      RECHECK_PERIOD = 50_000_000
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  sysid_boot_checker_if.master sysid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic [3:0]           retry_count,
  output logic [DATA_W-1:0]    captured_id,
  output logic [DATA_W-1:0]    captured_ts
);

  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

  state_t            r_state, w_state_nxt;
  logic              r_auto;
  logic              w_sample, w_load, w_in_read, w_start, w_recheck;
  logic              r_addr, w_addr_nxt, r_read, w_read_nxt;
  logic              r_busy, w_busy_nxt, r_done, w_done_nxt, r_pass, w_pass_nxt;
  logic              r_id_ok, w_id_ok_nxt, r_ts_ok, w_ts_ok_nxt;
  logic [3:0]        r_retry, w_retry_nxt;
  logic [DATA_W-1:0] r_cap_id, w_cap_id_nxt, r_cap_ts, w_cap_ts_nxt;

  assign w_in_read = (r_state == RD_ID) || (r_state == RD_TS);
  assign w_start   = start | r_auto;
  // Timer parks at READ_LATENCY outside reads so each read phase starts fully loaded.
  assign w_load    = ~w_in_read | w_sample;

  sysid_read_timer #(.LOAD_VAL(READ_LATENCY)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .o_sample (w_sample)
  );

`ifdef SYSID_PERIODIC_RECHECK_EN
  logic [31:0] r_rck_cnt;

  assign w_recheck = (r_state == DONE) && (r_rck_cnt == 32'(RECHECK_PERIOD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rck_cnt <= '0;
    end else if ((r_state == DONE) && (w_state_nxt == DONE)) begin
      r_rck_cnt <= r_rck_cnt + 32'd1;
    end else begin
      r_rck_cnt <= '0;
    end
  end
`else
  assign w_recheck = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pass_nxt   = r_pass;
    w_id_ok_nxt  = r_id_ok;
    w_ts_ok_nxt  = r_ts_ok;
    w_retry_nxt  = r_retry;
    w_cap_id_nxt = r_cap_id;
    w_cap_ts_nxt = r_cap_ts;
    case (r_state)
      IDLE: if (w_start) w_state_nxt = RD_ID;
      RD_ID: begin
        if (w_sample) begin
          w_cap_id_nxt = sysid.sysid_readdata;
          w_id_ok_nxt  = (sysid.sysid_readdata == EXPECTED_ID);
          w_state_nxt  = RD_TS;
        end
      end
      RD_TS: begin
        if (w_sample) begin
          w_cap_ts_nxt = sysid.sysid_readdata;
          w_ts_ok_nxt  = (sysid.sysid_readdata == EXPECTED_TS);
          w_state_nxt  = CMP;
        end
      end
      CMP: begin
        if (r_id_ok && r_ts_ok) begin
          w_pass_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_retry < MAX_R) begin
          w_retry_nxt = r_retry + 4'd1;
          w_state_nxt = RD_ID;
        end else begin
          w_pass_nxt  = 1'b0;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // A periodic recheck keeps the previous verdict visible until its own CMP.
        if (w_start || w_recheck) begin
          w_state_nxt = RD_ID;
          w_id_ok_nxt = 1'b0;
          w_ts_ok_nxt = 1'b0;
          w_retry_nxt = 4'd0;
          if (w_start) w_pass_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = is_active(w_state_nxt);
    w_done_nxt = (w_state_nxt == DONE);
    w_read_nxt = (w_state_nxt == RD_ID) || (w_state_nxt == RD_TS);
    w_addr_nxt = (w_state_nxt == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_auto   <= AUTO_START;
      r_addr   <= 1'b0;
      r_read   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_id_ok  <= 1'b0;
      r_ts_ok  <= 1'b0;
      r_retry  <= 4'd0;
      r_cap_id <= '0;
      r_cap_ts <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_auto   <= 1'b0;
      r_addr   <= w_addr_nxt;
      r_read   <= w_read_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_pass   <= w_pass_nxt;
      r_id_ok  <= w_id_ok_nxt;
      r_ts_ok  <= w_ts_ok_nxt;
      r_retry  <= w_retry_nxt;
      r_cap_id <= w_cap_id_nxt;
      r_cap_ts <= w_cap_ts_nxt;
    end
  end

  assign sysid.sysid_address = r_addr;
  assign sysid.sysid_read    = r_read;
  assign busy                = r_busy;
  assign done                = r_done;
  assign pass                = r_pass;
  assign id_ok               = r_id_ok;
  assign ts_ok               = r_ts_ok;
  assign retry_count         = r_retry;
  assign captured_id         = r_cap_id;
  assign captured_ts         = r_cap_ts;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: slave model returns bad words for the first N attempts of each word.
module tb_sysid_boot_checker;
  import sysid_check_pkg::*;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1671663468;
  localparam int          MAXR   = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, id_ok, ts_ok;
  logic [3:0]  retry_count;
  logic [31:0] captured_id, captured_ts;

  sysid_boot_checker_if bus ();

  sysid_boot_checker #(
    .EXPECTED_ID  (EXP_ID),
    .EXPECTED_TS  (EXP_TS),
    .READ_LATENCY (1),
    .MAX_RETRIES  (MAXR),
    .AUTO_START   (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .sysid       (bus.master),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .id_ok       (id_ok),
    .ts_ok       (ts_ok),
    .retry_count (retry_count),
    .captured_id (captured_id),
    .captured_ts (captured_ts)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_err    = 0;
  int          id_phases = 0;
  int          base_phase = 0;
  int          id_bad = 0;
  int          ts_bad = 0;
  int          att;
  logic [31:0] bad_id = 32'hDEAD_BEEF;
  logic [31:0] bad_ts = 32'h1234_5678;
  logic        prev_idph = 1'b0;

  // Attempt index = number of ID read phases seen since the current check began.
  always @(negedge clock) begin
    if (bus.sysid_read && (bus.sysid_address == SYSID_ADDR_ID) && !prev_idph)
      id_phases++;
    prev_idph = bus.sysid_read && (bus.sysid_address == SYSID_ADDR_ID);
  end

  always_comb begin
    att = id_phases - base_phase - 1;
    if (bus.sysid_address == SYSID_ADDR_TS)
      bus.sysid_readdata = (att < ts_bad) ? bad_ts : EXP_TS;
    else
      bus.sysid_readdata = (att < id_bad) ? bad_id : EXP_ID;
  end

  typedef struct {
    int   ib;
    int   tb;
    int   extra;
    logic e_pass;
    int   e_retry;
    logic e_idok;
    logic e_tsok;
    int   e_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_flags"}, 32'({busy, done, pass, id_ok, ts_ok, retry_count,
                             bus.sysid_read, bus.sysid_address}), 32'd0);
    chk({nm, "_cap_id"}, captured_id, 32'd0);
    chk({nm, "_cap_ts"}, captured_ts, 32'd0);
  endtask

  // Counts cycles after the start-sampling edge until done; start is held only for 'extra' cycle if nonzero.
  task automatic wait_done(input int extra, output int lat);
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      lat++;
      start = (lat == extra);
      if (lat == 1) begin
        chk("first_cycle_done", 32'(done), 32'd0);
        chk("first_cycle_busy", 32'(busy), 32'd1);
      end
      if (done) break;
    end
    start = 1'b0;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: done still 0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic run_check(input int ib, input int tb, input int extra, output int lat);
    @(negedge clock);
    id_bad     = ib;
    ts_bad     = tb;
    base_phase = id_phases;
    start      = 1'b1;
    wait_done(extra, lat);
  endtask

  // Reference: the first attempt with both words good passes; otherwise fail after MAXR retries.
  task automatic predict(input int ib, input int tb, output logic p, output int r,
                         output logic iok, output logic tok, output int lat,
                         output logic [31:0] cid, output logic [31:0] cts);
    int k, last;
    k = (ib > tb) ? ib : tb;
    if (k <= MAXR) begin
      p = 1'b1; r = k; last = k;
    end else begin
      p = 1'b0; r = MAXR; last = MAXR;
    end
    iok = (last >= ib);
    tok = (last >= tb);
    lat = 2 * (1 + 1) + 2 + r * (2 * (1 + 1) + 1);
    cid = iok ? EXP_ID : bad_id;
    cts = tok ? EXP_TS : bad_ts;
  endtask

  initial begin
    int          lat, r, e_lat;
    logic        p, iok, tok;
    logic [31:0] cid, cts;

    vecs[0] = '{ib:0, tb:0, extra:0, e_pass:1'b1, e_retry:0, e_idok:1'b1, e_tsok:1'b1, e_lat:6};
    vecs[1] = '{ib:1, tb:0, extra:3, e_pass:1'b1, e_retry:1, e_idok:1'b1, e_tsok:1'b1, e_lat:11};
    vecs[2] = '{ib:0, tb:9, extra:0, e_pass:1'b0, e_retry:3, e_idok:1'b1, e_tsok:1'b0, e_lat:21};
    vecs[3] = '{ib:9, tb:9, extra:5, e_pass:1'b0, e_retry:3, e_idok:1'b0, e_tsok:1'b0, e_lat:21};
    vecs[4] = '{ib:2, tb:3, extra:0, e_pass:1'b1, e_retry:3, e_idok:1'b1, e_tsok:1'b1, e_lat:21};
    vecs[5] = '{ib:4, tb:0, extra:0, e_pass:1'b0, e_retry:3, e_idok:1'b0, e_tsok:1'b1, e_lat:21};
    vecs[6] = '{ib:0, tb:2, extra:4, e_pass:1'b1, e_retry:2, e_idok:1'b1, e_tsok:1'b1, e_lat:16};

    // Reset asserted together with start: reset wins, everything stays at zero.
    #2 reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    start      = 1'b0;
    base_phase = id_phases;
    reset      = 1'b0;
    wait_done(0, lat);
    chk("auto_lat", lat, 6);
    chk("auto_pass", 32'(pass), 32'd1);
    chk("auto_cap_ts", captured_ts, EXP_TS);
    chk("auto_retry", 32'(retry_count), 32'd0);

    foreach (vecs[i]) begin
      run_check(vecs[i].ib, vecs[i].tb, vecs[i].extra, lat);
      predict(vecs[i].ib, vecs[i].tb, p, r, iok, tok, e_lat, cid, cts);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].e_lat);
      chk($sformatf("vec%0d_pass", i), 32'(pass), 32'(vecs[i].e_pass));
      chk($sformatf("vec%0d_retry", i), 32'(retry_count), vecs[i].e_retry);
      chk($sformatf("vec%0d_id_ok", i), 32'(id_ok), 32'(vecs[i].e_idok));
      chk($sformatf("vec%0d_ts_ok", i), 32'(ts_ok), 32'(vecs[i].e_tsok));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d_cap_id", i), captured_id, cid);
      chk($sformatf("vec%0d_cap_ts", i), captured_ts, cts);
    end

    // Asynchronous reset in the middle of the timestamp read.
    @(negedge clock);
    id_bad = 0; ts_bad = 0; base_phase = id_phases; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_addr", 32'(bus.sysid_address), 32'd1);
    #1 reset = 1'b1;
    #1 chk_zero("abort");
    @(negedge clock);
    @(negedge clock);
    base_phase = id_phases;
    reset      = 1'b0;
    wait_done(0, lat);
    chk("rearm_lat", lat, 6);
    chk("rearm_pass", 32'(pass), 32'd1);

    for (int n = 0; n < 12; n++) begin
      int ib, tb;
      ib     = $urandom_range(0, 5);
      tb     = $urandom_range(0, 5);
      bad_id = $urandom | 32'd1;
      bad_ts = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
      run_check(ib, tb, 0, lat);
      predict(ib, tb, p, r, iok, tok, e_lat, cid, cts);
      chk($sformatf("rnd%0d_lat", n), lat, e_lat);
      chk($sformatf("rnd%0d_pass", n), 32'(pass), 32'(p));
      chk($sformatf("rnd%0d_retry", n), 32'(retry_count), r);
      chk($sformatf("rnd%0d_id_ok", n), 32'(id_ok), 32'(iok));
      chk($sformatf("rnd%0d_ts_ok", n), 32'(ts_ok), 32'(tok));
      chk($sformatf("rnd%0d_cap_id", n), captured_id, cid);
      chk($sformatf("rnd%0d_cap_ts", n), captured_ts, cts);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
